// File: rtl/pong_pkg.sv
// Shared types and default playfield constants for the Pong paddle logic.
package pong_pkg;

  typedef enum logic [1:0] {IDLE, UP, DOWN} paddle_state_t;
  typedef enum logic [1:0] {CMD_NONE, CMD_UP, CMD_DOWN} paddle_cmd_t;

  localparam int DEF_SCREEN_HEIGHT = 480;
  localparam int DEF_SCREEN_WIDTH  = 640;

  // Opposing buttons cancel each other out.
  function automatic paddle_cmd_t decode_cmd(input logic up, input logic dn);
    if (up && !dn)      return CMD_UP;
    else if (dn && !up) return CMD_DOWN;
    else                return CMD_NONE;
  endfunction

endpackage

// File: rtl/paddle_speed_ramp.sv
// Hold counter plus saturating speed register; next_speed is the step for the current tick.
module paddle_speed_ramp
  import pong_pkg::*;
#(
  parameter int MAX_SPEED    = 4,
  parameter int ACCEL_PERIOD = 8,
  parameter int SPD_W        = $clog2(MAX_SPEED + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic             restart,
  input  logic             clear,
  output logic [SPD_W-1:0] next_speed,
  output logic [SPD_W-1:0] speed
);

  localparam int HOLD_W = (ACCEL_PERIOD > 1) ? $clog2(ACCEL_PERIOD) : 1;

  logic [SPD_W-1:0]  speed_d, speed_q;
  logic [HOLD_W-1:0] hold_d, hold_q;

  // clear wins over restart, restart wins over advance
  always_comb begin
    speed_d = speed_q;
    hold_d  = hold_q;
    if (clear) begin
      speed_d = '0;
      hold_d  = '0;
    end else if (restart) begin
      speed_d = SPD_W'(1);
      hold_d  = '0;
    end else if (advance) begin
      if (hold_q == HOLD_W'(ACCEL_PERIOD - 1)) begin
        hold_d = '0;
        if (speed_q < SPD_W'(MAX_SPEED)) speed_d = speed_q + SPD_W'(1);
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      speed_q <= '0;
      hold_q  <= '0;
    end else begin
      speed_q <= speed_d;
      hold_q  <= hold_d;
    end
  end

  assign next_speed = speed_d;
  assign speed      = speed_q;

endmodule

// File: rtl/paddle_accel.sv
// Pong paddle tracker with held-direction acceleration and playfield clamping.
// Optional PADDLE_AI_EN macro adds ai_mode/target_y auto-tracking.
module paddle_accel
  import pong_pkg::*;
#(
  parameter int Y_W           = 9,
  parameter int Y0            = 240,
  parameter int PADDLE_HEIGHT = 70,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int MAX_SPEED     = 4,
  parameter int ACCEL_PERIOD  = 8,
  parameter int DEADBAND      = 4,
  parameter int SPD_W         = $clog2(MAX_SPEED + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             tick,
  input  logic             move_up,
  input  logic             move_down,
  output logic [Y_W-1:0]   y_min,
  output logic [SPD_W-1:0] speed,
  output logic             moving_up,
  output logic             moving_down,
  output logic             at_top,
  output logic             at_bottom,
  output logic             bump
`ifdef PADDLE_AI_EN
  ,
  input  logic             ai_mode,
  input  logic [Y_W-1:0]   target_y
`endif
);

  localparam int Y_MAX = SCREEN_HEIGHT - PADDLE_HEIGHT;

  generate
    if (Y0 > Y_MAX || Y_MAX >= (2 ** Y_W) || Y_MAX < 0 || MAX_SPEED < 1
        || ACCEL_PERIOD < 1 || DEADBAND < 0) begin : g_bad_cfg
      $error("paddle_accel: invalid parameter combination");
    end
  endgenerate

  paddle_state_t    state_d, state_q;
  logic [Y_W-1:0]   y_d, y_q;
  logic             bump_d, bump_q;
  paddle_cmd_t      cmd;
  logic             fire, match;
  logic             rmp_adv, rmp_rst, rmp_clr;
  logic [SPD_W-1:0] step;
  logic [Y_W:0]     y_ext, step_ext, sum_ext;

`ifdef PADDLE_AI_EN
  localparam int CW = Y_W + 2;
  logic [CW-1:0] center, tgt_ext;

  assign center  = CW'(y_q) + CW'(PADDLE_HEIGHT / 2);
  assign tgt_ext = CW'(target_y);

  always_comb begin
    cmd = decode_cmd(move_up, move_down);
    if (ai_mode) begin
      if (tgt_ext + CW'(DEADBAND) < center)      cmd = CMD_UP;
      else if (tgt_ext > center + CW'(DEADBAND)) cmd = CMD_DOWN;
      else                                       cmd = CMD_NONE;
    end
  end
`else
  assign cmd = decode_cmd(move_up, move_down);
`endif

  assign fire  = start && tick;
  assign match = (cmd == CMD_UP && state_q == UP) || (cmd == CMD_DOWN && state_q == DOWN);

  assign rmp_clr = !start || (fire && cmd == CMD_NONE);
  assign rmp_rst = fire && cmd != CMD_NONE && !match;
  assign rmp_adv = fire && match;

  paddle_speed_ramp #(
    .MAX_SPEED   (MAX_SPEED),
    .ACCEL_PERIOD(ACCEL_PERIOD),
    .SPD_W       (SPD_W)
  ) u_ramp (
    .clk       (clk),
    .reset     (reset),
    .advance   (rmp_adv),
    .restart   (rmp_rst),
    .clear     (rmp_clr),
    .next_speed(step),
    .speed     (speed)
  );

  // one extra bit so the down-sum and the up-compare cannot wrap
  assign y_ext    = {1'b0, y_q};
  assign step_ext = (Y_W + 1)'(step);
  assign sum_ext  = y_ext + step_ext;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    bump_d  = 1'b0;
    if (!start) begin
      state_d = IDLE;
    end else if (tick) begin
      case (cmd)
        CMD_UP: begin
          state_d = UP;
          if (y_ext < step_ext) begin
            y_d    = '0;
            bump_d = 1'b1;
          end else begin
            y_d = y_q - Y_W'(step);
          end
        end
        CMD_DOWN: begin
          state_d = DOWN;
          if (sum_ext > (Y_W + 1)'(Y_MAX)) begin
            y_d    = Y_W'(Y_MAX);
            bump_d = 1'b1;
          end else begin
            y_d = sum_ext[Y_W-1:0];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      y_q     <= Y_W'(Y0);
      bump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      bump_q  <= bump_d;
    end
  end

  assign y_min       = y_q;
  assign moving_up   = (state_q == UP);
  assign moving_down = (state_q == DOWN);
  assign at_top      = (y_q == '0);
  assign at_bottom   = (y_q == Y_W'(Y_MAX));
  assign bump        = bump_q;

endmodule

// File: tb/tb_paddle_accel.sv
// Scoreboard bench for paddle_accel: behavioural model feeds an expected queue, plus fixed sequences.
module tb_paddle_accel;

  localparam int Y_W = 9, Y0 = 25, PH = 10, SH = 50, MS = 3, AP = 2, DB = 4;
  localparam int YM = SH - PH;
  localparam int SW = $clog2(MS + 1);

  logic clk = 1'b0;
  logic reset, start, tick, move_up, move_down;
  logic [Y_W-1:0] y_min;
  logic [SW-1:0]  speed;
  logic moving_up, moving_down, at_top, at_bottom, bump;
  logic ai_mode;
  logic [Y_W-1:0] target_y;

  always #5 clk = ~clk;

  paddle_accel #(
    .Y_W(Y_W), .Y0(Y0), .PADDLE_HEIGHT(PH), .SCREEN_HEIGHT(SH),
    .MAX_SPEED(MS), .ACCEL_PERIOD(AP), .DEADBAND(DB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .tick(tick),
    .move_up(move_up), .move_down(move_down),
    .y_min(y_min), .speed(speed), .moving_up(moving_up), .moving_down(moving_down),
    .at_top(at_top), .at_bottom(at_bottom), .bump(bump)
`ifdef PADDLE_AI_EN
    , .ai_mode(ai_mode), .target_y(target_y)
`endif
  );

  typedef struct {
    int y; int spd; int up; int dn; int top; int bot; int bmp;
  } exp_t;

  exp_t sb[$];
  int errs = 0, checks = 0;
  int m_y, m_st, m_spd, m_hold, m_bump;  // m_st: 0 idle, 1 up, 2 down

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model(input bit rst, s, t, u, d, input bit ai, input int tgt);
    int cmd, ctr;
    if (rst) begin
      m_y = Y0; m_st = 0; m_spd = 0; m_hold = 0; m_bump = 0;
    end else if (!s) begin
      m_st = 0; m_spd = 0; m_hold = 0; m_bump = 0;
    end else if (!t) begin
      m_bump = 0;
    end else begin
      cmd = (u && !d) ? 1 : (d && !u) ? 2 : 0;
`ifdef PADDLE_AI_EN
      if (ai) begin
        ctr = m_y + PH / 2;
        cmd = (tgt + DB < ctr) ? 1 : (tgt > ctr + DB) ? 2 : 0;
      end
`else
      ctr = ai ? tgt : 0;
`endif
      if (cmd == 0) begin
        m_st = 0; m_spd = 0; m_hold = 0; m_bump = 0;
      end else begin
        if (cmd == m_st) begin
          if (m_hold == AP - 1) begin
            m_hold = 0;
            if (m_spd < MS) m_spd++;
          end else m_hold++;
        end else begin
          m_st = cmd; m_spd = 1; m_hold = 0;
        end
        if (cmd == 1) begin
          m_bump = (m_y < m_spd);
          m_y = m_bump ? 0 : m_y - m_spd;
        end else begin
          m_bump = (m_y + m_spd > YM);
          m_y = m_bump ? YM : m_y + m_spd;
        end
      end
    end
  endtask

  // drive one cycle, push the model's prediction, compare after the edge
  task automatic cyc(input bit rst, s, t, u, d, input bit ai = 0, input int tgt = 0);
    exp_t e;
    reset = rst; start = s; tick = t; move_up = u; move_down = d;
    ai_mode = ai; target_y = Y_W'(tgt);
    model(rst, s, t, u, d, ai, tgt);
    e = '{m_y, m_spd, int'(m_st == 1), int'(m_st == 2), int'(m_y == 0), int'(m_y == YM), m_bump};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("y_min", int'(y_min), e.y);
    chk("speed", int'(speed), e.spd);
    chk("moving_up", int'(moving_up), e.up);
    chk("moving_down", int'(moving_down), e.dn);
    chk("at_top", int'(at_top), e.top);
    chk("at_bottom", int'(at_bottom), e.bot);
    chk("bump", int'(bump), e.bmp);
  endtask

  initial begin
    int y2[5] = '{24, 23, 21, 19, 16};
    int s2[5] = '{1, 1, 2, 2, 3};
    int y3[8] = '{26, 27, 29, 31, 34, 37, 40, 40};
    int y5[4] = '{2, 1, 0, 0};
    bit dir_u, dir_d;

    // reset state
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 0);
    chk("rst_y", int'(y_min), 25);
    chk("rst_spd", int'(speed), 0);

    // up ramp with idle cycles between strobes
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 1, 1, 0);
      chk("up_y", int'(y_min), y2[i]);
      chk("up_spd", int'(speed), s2[i]);
      cyc(0, 1, 0, 1, 0);
      chk("notick_y", int'(y_min), y2[i]);
    end

    // reversal then both pressed
    cyc(0, 1, 1, 0, 1);
    chk("rev_y", int'(y_min), 17);
    chk("rev_spd", int'(speed), 1);
    chk("rev_dn", int'(moving_down), 1);
    cyc(0, 1, 1, 1, 1);
    chk("both_y", int'(y_min), 17);
    chk("both_spd", int'(speed), 0);
    chk("both_idle", int'({moving_up, moving_down}), 0);

    // reset mid-move
    cyc(0, 1, 1, 0, 1);
    cyc(0, 1, 1, 0, 1);
    cyc(1, 1, 1, 0, 1);
    chk("midrst_y", int'(y_min), 25);
    chk("midrst_spd", int'(speed), 0);
    chk("midrst_bump", int'(bump), 0);

    // down into the bottom edge
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1, 0, 1);
      chk("dn_y", int'(y_min), y3[i]);
      chk("dn_bump", int'(bump), int'(i == 7));
      chk("dn_bot", int'(at_bottom), int'(i >= 6));
    end
    cyc(0, 1, 0, 0, 1);
    chk("bump_clr", int'(bump), 0);

    // reposition to y=3, then push into the top edge at speed 2
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 0, 0);
    chk("pos_y", int'(y_min), 4);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 0, 0);
    chk("pos_y3", int'(y_min), 3);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 1, 0);
      chk("top_y", int'(y_min), y5[i]);
      chk("top_bump", int'(bump), int'(i >= 2));
    end
    chk("top_spd", int'(speed), 2);
    cyc(0, 1, 1, 0, 0);
    chk("rel_bump", int'(bump), 0);
    chk("rel_top", int'(at_top), 1);

    // start low freezes position and clears speed
    cyc(0, 1, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    chk("stop_y", int'(y_min), 1);
    chk("stop_spd", int'(speed), 0);

`ifdef PADDLE_AI_EN
    // AI tracking up toward a low target; manual down input ignored
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, 0, 1, 1, 5);
    chk("ai_settled", int'(int'(y_min) + PH / 2 <= 5 + DB), 1);
    chk("ai_idle", int'({moving_up, moving_down}), 0);
    for (int i = 0; i < 60; i++)
      cyc(0, 1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 1,
          $urandom_range(0, 60));
`endif

    // random held-direction traffic against the model
    dir_u = 0; dir_d = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        dir_u = $urandom_range(0, 1);
        dir_d = $urandom_range(0, 1);
      end
      cyc($urandom_range(0, 79) == 0, $urandom_range(0, 11) != 0,
          $urandom_range(0, 1), dir_u, dir_d);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
